// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the SOPC memory bus arbiter.
//   - FSM state encoding (idle / issue / wait / respond)
//   - Owner encoding (instruction fetch vs. data memory port)
//   - RAM strobe constants and latency counter width
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } owner_e;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  // Wide enough for MEM_LAT up to 15.
  localparam int unsigned CntW = 4;

  // Counter preload for the cycles still to wait after the issue cycle.
  function automatic logic [CntW-1:0] lat_load(input int unsigned lat);
    return CntW'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the memory bus arbiter.
// The grant is purely combinational from the two request lines; it is only
// consumed by the parent while idle.
//
// Build option: ARB_RR_EN
//   defined   - round-robin: a last-owner flag, updated on each completion,
//               hands a simultaneous request to the port not served last.
//               The flag resets to "fetch served last", so data wins first.
//   undefined - fixed priority, data port over fetch port; no flag exists.
//
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset (flag only)
//   if_req_i       fetch port request
//   mem_req_i      data port request
//   resp_i         completion cycle of the current transaction
//   resp_owner_i   owner of the completing transaction (owner_e encoding)
//   grant_o        selected owner (owner_e encoding)
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic mem_req_i,
  input  logic resp_i,
  input  logic resp_owner_i,
  output logic grant_o
);

`ifdef ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (resp_i) begin
      last_d = resp_owner_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= OwnIf;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    grant_o = OwnIf;
    if (if_req_i && mem_req_i) begin
      // Tie goes to whichever port did not complete last.
      grant_o = (last_q == OwnIf) ? OwnMem : OwnIf;
    end else if (mem_req_i) begin
      grant_o = OwnMem;
    end
  end
`else
  // Fixed priority needs no history; these inputs are intentionally ignored.
  logic unused_rr;
  assign unused_rr = ^{clk_i, rst_i, resp_i, resp_owner_i, if_req_i};

  always_comb begin
    grant_o = OwnIf;
    if (mem_req_i) begin
      grant_o = OwnMem;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one single-port SRAM between the OpenMIPS
// instruction-fetch port and the MEM-stage data port.
//
// One transaction at a time: IDLE latches the winner's command, ISSUE drives
// the RAM for a single cycle, WAIT counts out the remaining RAM latency and
// captures read data, RESP pulses the owner's rvalid. stall_req freezes the
// pipeline while any request is pending and not completing this cycle.
//
// Build option: ARB_RR_EN selects round-robin arbitration (see mem_arb_pick);
// default is fixed data-over-fetch priority.
//
// Parameters: ADDR_W byte address width, DATA_W data width, MEM_LAT RAM
// latency in cycles from issue to valid ram_rdata (1..15).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_rvalid)
//   if_rdata/if_rvalid            fetch data and one-cycle completion pulse
//   mem_req/we/sel/addr/wdata     data request (held until mem_rvalid)
//   mem_rdata/mem_rvalid          data read data and completion pulse
//   ram_ce/we/sel/addr/wdata      RAM command, active in the issue cycle only
//   ram_rdata                     RAM read data
//   stall_req                     pipeline freeze request
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_rvalid,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [DATA_W/8-1:0]   mem_sel,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_rvalid,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [DATA_W/8-1:0]   ram_sel,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  stall_req
);

  localparam int unsigned SelW = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                cmd_we_q, cmd_we_d;
  logic [SelW-1:0]     cmd_sel_q, cmd_sel_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic grant;
  logic resp;
  logic capture;

  mem_arb_pick u_pick (
    .clk_i        (clk),
    .rst_i        (rst),
    .if_req_i     (if_req),
    .mem_req_i    (mem_req),
    .resp_i       (resp),
    .resp_owner_i (owner_q),
    .grant_o      (grant)
  );

  // Next-state and command latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req || mem_req) begin
          owner_d = owner_e'(grant);
          if (grant == OwnMem) begin
            cmd_we_d    = mem_we;
            cmd_sel_d   = mem_sel;
            cmd_addr_d  = mem_addr;
            cmd_wdata_d = mem_wdata;
          end else begin
            // Fetches are always full-word reads.
            cmd_we_d    = WriteDisable;
            cmd_sel_d   = '1;
            cmd_addr_d  = if_addr;
            cmd_wdata_d = '0;
          end
          state_d = StIssue;
        end
      end

      StIssue: begin
        cnt_d = lat_load(MEM_LAT);
        if (MEM_LAT == 1) begin
          // Single-cycle RAM: data is already valid at the end of issue.
          capture = 1'b1;
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end

      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read data is steered to the owner's holding register, which keeps its
  // value until that port's next completion.
  always_comb begin
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if (capture) begin
      if (owner_q == OwnIf) begin
        if_rdata_d = ram_rdata;
      end else begin
        mem_rdata_d = ram_rdata;
      end
    end
  end

  // RAM command is only presented during the issue cycle; zero otherwise.
  always_comb begin
    ram_ce    = ChipDisable;
    ram_we    = WriteDisable;
    ram_sel   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state_q == StIssue) begin
      ram_ce    = ChipEnable;
      ram_we    = cmd_we_q;
      ram_sel   = cmd_sel_q;
      ram_addr  = cmd_addr_q;
      ram_wdata = cmd_wdata_q;
    end
  end

  always_comb begin
    resp       = (state_q == StResp);
    if_rvalid  = resp && (owner_q == OwnIf);
    mem_rvalid = resp && (owner_q == OwnMem);
    // Release the pipeline in the completion cycle itself.
    stall_req  = (if_req || mem_req) && !(if_rvalid || mem_rvalid);
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      cmd_we_q    <= WriteDisable;
      cmd_sel_q   <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reset checks, a table of single
// transactions, hand-written contention / reset / withdrawal sequences, and a
// randomized phase compared against a transaction-timeline reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        ram_ce;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        stall_req;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_rvalid  (if_rvalid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_sel    (ram_sel),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .stall_req  (stall_req)
  );

  // Bench RAM: 64 words, registered read (data valid the cycle after issue,
  // held until the next read), byte-enable writes, plus a preload port.
  logic [31:0] ram_mem [64];
  logic [31:0] ram_rd_q;
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_en) begin
      ram_mem[pl_idx] <= pl_val;
    end else if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_sel[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_rd_q <= ram_mem[ram_addr[7:2]];
      end
    end
  end
  assign ram_rdata = ram_rd_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Shadow of the RAM contents as the specification says they should be.
  logic [31:0] model_mem [64];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  // One isolated transaction: ce exactly once in the cycle after the request,
  // completion MEM_LAT+1 cycles after it, on the right port, with the right data.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int ce_cnt;
    lat    = 0;
    ce_cnt = 0;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_sel = v.sel; mem_addr = v.addr; mem_wdata = v.wdata;
      if (v.we) model_mem[v.addr[7:2]] = merge(model_mem[v.addr[7:2]], v.wdata, v.sel);
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, " ce"}, ram_ce, 1'b1);
        chk({tag, " cmd"}, {ram_we, ram_sel, ram_addr},
            {v.is_mem & v.we, (v.is_mem ? v.sel : 4'hf), v.addr});
        if (v.is_mem && v.we) chk({tag, " wdata"}, ram_wdata, v.wdata);
      end
      if (ram_ce) ce_cnt++;
      if (if_rvalid || mem_rvalid) begin
        lat = c;
        break;
      end
    end
    chk({tag, " latency"}, lat, MEM_LAT + 1);
    if (lat != 0) begin
      chk({tag, " port"}, {if_rvalid, mem_rvalid}, v.is_mem ? 2'b01 : 2'b10);
      chk({tag, " stall"}, stall_req, 1'b0);
      if (v.chk_rd) chk({tag, " rdata"}, v.is_mem ? mem_rdata : if_rdata, v.exp_rd);
    end
    chk({tag, " ce count"}, ce_cnt, 1);
    if_req  = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [5:0] w;
    w = 6'($urandom_range(0, 63));
    return {24'h0, w, 2'b00};
  endfunction

  // Reference model state for the random phase: one transaction in flight,
  // identified by its position on the fixed issue/respond timeline.
  logic        m_busy;
  int          m_ph;
  logic        m_own;    // 1 = data port
  logic        m_last;   // 1 = data port served last
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rd;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          got_c [$];
    logic        got_p [$];
    logic [3:0]  exp_ord;
    int          rv_cnt;
    int          rv_c;
    int          ce_cnt;
    logic [31:0] rv_data;
    vec_t        fresh;
    logic        e_ce, e_irv, e_mrv, e_stall;

    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = '0; mem_wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;

    vecs[0] = '{1'b0, 1'b0, 4'hf, 32'h100, 32'h0,         1'b1, 32'h3401_0020};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h204, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 4'hf, 32'h204, 32'h0,         1'b1, 32'h1111_BEEF};
    vecs[3] = '{1'b0, 1'b0, 4'hf, 32'h204, 32'h0,         1'b1, 32'h1111_BEEF};
    vecs[4] = '{1'b1, 1'b1, 4'hC, 32'h100, 32'hCAFE_0000, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 4'hf, 32'h100, 32'h0,         1'b1, 32'hCAFE_0020};

    // Reset held for 64 cycles with a fetch pending; RAM preloaded meanwhile.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i % 16 == 3) begin
        chk("reset ctl", {ram_ce, ram_we, ram_sel, if_rvalid, mem_rvalid, stall_req}, 9'b0_0_0000_001);
        chk("reset rdata", {if_rdata, mem_rdata}, 64'h0);
      end
      pl_en  = 1'b1;
      pl_idx = 6'(i);
      pl_val = (i == 0) ? 32'h3401_0020 : (i == 1) ? 32'h1111_2222 : $urandom;
      model_mem[i] = pl_val;
    end
    @(negedge clk);
    pl_en = 1'b0;
    rst   = 1'b0;

    // Table of isolated transactions; entry 0 also covers the first ce after reset.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Contention with both ports re-requesting continuously.
`ifdef ARB_RR_EN
    exp_ord = 4'b1010;
`else
    exp_ord = 4'b1111;
`endif
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hf; mem_addr = 32'h008;
    if_req  = 1'b1; if_addr = 32'h00C;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_rvalid) begin
        got_c.push_back(c); got_p.push_back(1'b1);
        chk("contend mem rdata", mem_rdata, model_mem[2]);
      end
      if (if_rvalid) begin
        got_c.push_back(c); got_p.push_back(1'b0);
        chk("contend if rdata", if_rdata, model_mem[3]);
      end
      if (got_c.size() >= 4) break;
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("contend count", got_c.size(), 4);
    if (got_c.size() >= 4) begin
      chk("contend first", got_c[0], MEM_LAT + 1);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("contend owner%0d", i), got_p[i], exp_ord[3-i]);
        if (i > 0) chk($sformatf("contend gap%0d", i), got_c[i] - got_c[i-1], MEM_LAT + 2);
      end
    end
    @(negedge clk);

    // Reset during WAIT drops the transaction silently.
    if_req = 1'b1; if_addr = 32'h010;
    @(negedge clk);
    chk("rstwait ce", ram_ce, 1'b1);
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("rstwait in reset", {ram_ce, if_rvalid, mem_rvalid}, 3'b000);
    rst = 1'b0;
    rv_cnt = 0; ce_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_rvalid || mem_rvalid) rv_cnt++;
      if (ram_ce) ce_cnt++;
    end
    chk("rstwait no rvalid", rv_cnt, 0);
    chk("rstwait no ce", ce_cnt, 0);
    fresh = '{1'b1, 1'b0, 4'hf, 32'h010, 32'h0, 1'b1, model_mem[4]};
    run_vec(fresh, "after rst");

    // Request withdrawn after issue still completes exactly once.
    if_req = 1'b1; if_addr = 32'h014;
    rv_cnt = 0; ce_cnt = 0; rv_c = 0; rv_data = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) if_req = 1'b0;
      if (ram_ce) ce_cnt++;
      if (if_rvalid) begin
        rv_cnt++; rv_c = c; rv_data = if_rdata;
      end
    end
    chk("withdraw rvalid count", rv_cnt, 1);
    chk("withdraw rvalid cycle", rv_c, MEM_LAT + 1);
    chk("withdraw ce count", ce_cnt, 1);
    chk("withdraw rdata", rv_data, model_mem[5]);

    // Randomized traffic against the timeline model.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_busy = 1'b0; m_ph = 0; m_own = 1'b0; m_last = 1'b0;
    m_we = 1'b0; m_sel = 4'h0; m_addr = '0; m_wdata = '0; m_rd = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      if (m_busy) begin
        m_ph++;
        if (m_ph == MEM_LAT + 1) begin
          m_busy = 1'b0;
          m_last = m_own;
        end
      end else if (if_req || mem_req) begin
`ifdef ARB_RR_EN
        m_own = (if_req && mem_req) ? ~m_last : mem_req;
`else
        m_own = mem_req;
`endif
        if (m_own) begin
          m_we = mem_we; m_sel = mem_sel; m_addr = mem_addr; m_wdata = mem_wdata;
        end else begin
          m_we = 1'b0; m_sel = 4'hf; m_addr = if_addr; m_wdata = '0;
        end
        if (m_we) model_mem[m_addr[7:2]] = merge(model_mem[m_addr[7:2]], m_wdata, m_sel);
        else      m_rd = model_mem[m_addr[7:2]];
        m_busy = 1'b1;
        m_ph   = 0;
      end

      @(negedge clk);
      e_ce    = m_busy && (m_ph == 0);
      e_irv   = m_busy && (m_ph == MEM_LAT) && !m_own;
      e_mrv   = m_busy && (m_ph == MEM_LAT) && m_own;
      e_stall = (if_req || mem_req) && !(e_irv || e_mrv);
      chk("rand ctl", {ram_ce, if_rvalid, mem_rvalid, stall_req}, {e_ce, e_irv, e_mrv, e_stall});
      if (e_ce) begin
        chk("rand cmd", {ram_we, ram_sel, ram_addr}, {m_we, m_sel, m_addr});
        if (m_we) chk("rand wdata", ram_wdata, m_wdata);
      end
      if (e_irv) chk("rand if rdata", if_rdata, m_rd);
      if (e_mrv && !m_we) chk("rand mem rdata", mem_rdata, m_rd);

      if (if_req) begin
        if (if_rvalid) begin
          if ($urandom_range(0, 1) == 1) if_addr = rand_addr();
          else if_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (mem_req) begin
        if (mem_rvalid) begin
          if ($urandom_range(0, 1) == 1) begin
            mem_we = 1'($urandom_range(0, 1)); mem_sel = 4'($urandom_range(1, 15));
            mem_addr = rand_addr(); mem_wdata = $urandom;
          end else begin
            mem_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1)); mem_sel = 4'($urandom_range(1, 15));
        mem_addr = rand_addr(); mem_wdata = $urandom;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    repeat (MEM_LAT + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares one single-port SRAM between the instruction-fetch port and the data-memory (MEM stage) port of the OpenMIPS pipeline inside the minimal SOPC.
- Serialises requests, drives the RAM for a fixed access latency and returns read data or a write acknowledge to the owning requester.
- Raises a stall request to the pipeline control unit while any access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width (byte selects are DATA_W/8)
- MEM_LAT, 2, cycles from RAM issue to valid ram_rdata; legal range 1..15

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_rvalid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data, valid with if_rvalid
- if_rvalid  out  1  one-cycle completion pulse
- mem_req  in  1  data request; held until mem_rvalid
- mem_we  in  1  1 = write
- mem_sel  in  DATA_W/8  byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  read data, valid with mem_rvalid
- mem_rvalid  out  1  one-cycle completion pulse (reads and writes)
- ram_ce, ram_we  out  1  RAM chip enable / write enable
- ram_sel  out  DATA_W/8  RAM byte enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- stall_req  out  1  to pipeline control; freeze request

## Operation
- FSM states:
  - IDLE: if any req, latch owner and command, go to ISSUE.
  - ISSUE: one cycle with ram_ce=1 and registered command, load counter with MEM_LAT-1; go to WAIT, or directly to RESP if MEM_LAT=1.
  - WAIT: decrement the counter; at 0, capture ram_rdata and go to RESP.
  - RESP: pulse the owner's rvalid with the captured data; go to IDLE.
- Arbitration, evaluated only in IDLE: with both requests asserted, mem wins (fixed priority).
- Fetch accesses: ram_we=0, ram_sel=all ones.
- Data accesses: mem_we and mem_sel pass through unchanged.
- Writes follow the same sequence; mem_rdata is don't-care on a write completion.
- A request deasserted mid-transaction does not abort it: the transaction completes and rvalid still pulses.
- stall_req = (if_req | mem_req) & ~(if_rvalid | mem_rvalid); combinational from state and inputs.
- Reset at any point: state→IDLE, the outstanding transaction is dropped, and no rvalid is issued.
- Reset values: all ram_* = 0, both rvalid = 0, both rdata = 0, owner = IF, stall_req follows inputs.

## Timing
- Request sampled at edge k (state IDLE) → ram_ce high in cycle k+1.
- ram_rdata captured at the end of cycle k+MEM_LAT.
- rvalid high in cycle k+MEM_LAT+1.
- Back in IDLE at k+MEM_LAT+2; a held request is then re-sampled.
- Minimum spacing between completions: MEM_LAT+2 cycles.
- The rdata outputs hold their value until the next completion.
- If the loser's request is held, it is served immediately after the winner's RESP.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - A last-owner flag is updated in RESP.
  - On simultaneous requests, the port not served last wins.
  - Reset value of the flag is "IF served last", so MEM wins first.
- ARB_RR_EN undefined: fixed MEM-over-IF priority, and no last-owner flag is implemented.

## Structure
- Shared package/defines file: state encodings (IDLE/ISSUE/WAIT/RESP), owner encoding (OWN_IF/OWN_MEM), ChipEnable/WriteEnable constants, counter width (4 bits).
- One sub-module, mem_arb_pick: combinational grant selection from if_req, mem_req and last-owner. It contains the only `ifdef ARB_RR_EN`.

## Test plan
- Reset: rst high for 10 cycles while if_req=1 → ram_ce=0, rvalids=0, stall_req=1; first ram_ce one cycle after rst falls.
- Single fetch: MEM_LAT=2, if_addr=0x100, RAM word 0x3401_0020.
  - ram_ce in the cycle after the request.
  - if_rvalid 3 cycles after the request, with if_rdata=0x3401_0020.
  - stall_req falls with if_rvalid.
- Data write: mem_we=1, sel=4'b0011, addr=0x204, wdata=0xDEAD_BEEF → ram_we=1, ram_sel=4'b0011 for one cycle; mem_rvalid after MEM_LAT+1 cycles.
- Contention: if_req and mem_req asserted at the same edge.
  - Without ARB_RR_EN: mem served first, then if.
  - With ARB_RR_EN, repeated double requests: the grants alternate MEM, IF, MEM, IF.
- Reset mid-WAIT: assert rst during WAIT → no rvalid pulse; a fresh request after reset completes normally.
- Withdrawn request: drop if_req the cycle after ISSUE → if_rvalid still pulses once; no second ram_ce.
